// File: rtl/lock_pkg.sv
// Shared types and widths for the door-lock sequencer.
// The PROG state exists only when LOCK_CODE_PROG_EN is defined.
package lock_pkg;

  localparam int STATE_W = 3;
  localparam int DCNT_W  = 4;
  localparam int FCNT_W  = 4;
  localparam int TMR_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
`ifdef LOCK_CODE_PROG_EN
    ,
    PROG    = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/lock_entry_sequencer_key_conditioner.sv
// Push-button front end: 2-flop synchroniser, stability filter and a one-cycle
// pulse on each accepted press (debounced 1->0); release produces nothing.
module key_conditioner #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = r_s2 ^ r_stable;
  assign w_accept = w_diff && (r_cnt == LAST);
  // Only a released->pressed acceptance is reported.
  assign o_pulse  = w_accept && r_stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_entry_sequencer.sv
// Binary-code door lock: key conditioning, code entry FSM, fail counter and lockout timer.
// Define LOCK_CODE_PROG_EN to add the key_prog_n input and the code-programming state.
module lock_entry_sequencer
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 7,
  parameter logic [CODE_LEN-1:0] CODE           = 7'b1110111,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 50_000_000,
  parameter int                  DEB_CYCLES     = 500_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_enter_n,
  input  logic               key_lock_n,
`ifdef LOCK_CODE_PROG_EN
  input  logic               key_prog_n,
`endif
  input  logic               sw_x,
  output logic               open,
  output logic               alarm,
  output logic [STATE_W-1:0] state,
  output logic [DCNT_W-1:0]  digit_cnt,
  output logic [FCNT_W-1:0]  fail_cnt
);

  state_t              r_state;
  state_t              w_nxt;
  logic [CODE_LEN-1:0] r_entry;
  logic [CODE_LEN-1:0] w_entry_n;
  logic [CODE_LEN-1:0] w_shift;
  logic [CODE_LEN-1:0] w_code;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [DCNT_W-1:0]   w_dcnt_n;
  logic [DCNT_W:0]     w_dcnt_inc;
  logic                w_last;
  logic [FCNT_W-1:0]   r_fail;
  logic [FCNT_W-1:0]   w_fail_n;
  logic [FCNT_W:0]     w_fail_inc;
  logic [TMR_W-1:0]    r_tmr;
  logic [TMR_W-1:0]    w_tmr_n;
  logic                r_open;
  logic                r_alarm;
  logic                w_open_n;
  logic                r_sw_s1;
  logic                r_sw_s2;
  logic                w_enter_p;
  logic                w_lock_p;

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_enter_n),
    .o_pulse (w_enter_p)
  );

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_lock (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_lock_n),
    .o_pulse (w_lock_p)
  );

`ifdef LOCK_CODE_PROG_EN
  logic                w_prog_p;
  logic [CODE_LEN-1:0] r_code;
  logic [CODE_LEN-1:0] w_code_n;

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_prog (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_prog_n),
    .o_pulse (w_prog_p)
  );

  assign w_code = r_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_code <= CODE;
    else          r_code <= w_code_n;
  end
`else
  assign w_code = CODE;
`endif

  assign w_shift    = {r_entry[CODE_LEN-2:0], r_sw_s2};
  assign w_dcnt_inc = {1'b0, r_dcnt} + 1'b1;
  assign w_last     = (w_dcnt_inc == (DCNT_W+1)'(CODE_LEN));
  assign w_fail_inc = {1'b0, r_fail} + 1'b1;

  always_comb begin
    w_nxt     = r_state;
    w_entry_n = r_entry;
    w_dcnt_n  = r_dcnt;
    w_fail_n  = r_fail;
    w_tmr_n   = r_tmr;
`ifdef LOCK_CODE_PROG_EN
    w_code_n  = r_code;
`endif
    case (r_state)
      IDLE: begin
        if (w_enter_p && !w_lock_p) begin
          w_entry_n = w_shift;
          w_dcnt_n  = DCNT_W'(1);
          w_nxt     = ENTRY;
        end
      end
      ENTRY: begin
        if (w_lock_p) begin
          w_entry_n = '0;
          w_dcnt_n  = '0;
          w_nxt     = IDLE;
        end else if (w_enter_p) begin
          w_entry_n = w_shift;
          w_dcnt_n  = w_dcnt_inc[DCNT_W-1:0];
          if (w_last) w_nxt = CHECK;
        end
      end
      // Key pulses arriving during the compare cycle are deliberately dropped.
      CHECK: begin
        w_entry_n = '0;
        w_dcnt_n  = '0;
        if (r_entry == w_code) begin
          w_fail_n = '0;
          w_nxt    = OPEN;
        end else if (w_fail_inc >= (FCNT_W+1)'(MAX_FAIL)) begin
          w_fail_n = FCNT_W'(MAX_FAIL);
          w_tmr_n  = TMR_W'(LOCKOUT_CYCLES - 1);
          w_nxt    = LOCKOUT;
        end else begin
          w_fail_n = w_fail_inc[FCNT_W-1:0];
          w_nxt    = IDLE;
        end
      end
      OPEN: begin
        if (w_lock_p) begin
          w_nxt = IDLE;
`ifdef LOCK_CODE_PROG_EN
        end else if (w_prog_p) begin
          w_nxt = PROG;
`endif
        end
      end
      LOCKOUT: begin
        if (r_tmr == '0) begin
          w_fail_n = '0;
          w_nxt    = IDLE;
        end else begin
          w_tmr_n = r_tmr - 1'b1;
        end
      end
`ifdef LOCK_CODE_PROG_EN
      PROG: begin
        if (w_lock_p) begin
          w_entry_n = '0;
          w_dcnt_n  = '0;
          w_nxt     = IDLE;
        end else if (w_enter_p) begin
          if (w_last) begin
            w_code_n  = w_shift;
            w_entry_n = '0;
            w_dcnt_n  = '0;
            w_nxt     = OPEN;
          end else begin
            w_entry_n = w_shift;
            w_dcnt_n  = w_dcnt_inc[DCNT_W-1:0];
          end
        end
      end
`endif
      default: begin
        w_entry_n = '0;
        w_dcnt_n  = '0;
        w_nxt     = IDLE;
      end
    endcase
  end

`ifdef LOCK_CODE_PROG_EN
  assign w_open_n = (w_nxt == OPEN) || (w_nxt == PROG);
`else
  assign w_open_n = (w_nxt == OPEN);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_entry <= '0;
      r_dcnt  <= '0;
      r_fail  <= '0;
      r_tmr   <= '0;
      r_open  <= 1'b0;
      r_alarm <= 1'b0;
      r_sw_s1 <= 1'b0;
      r_sw_s2 <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_entry <= w_entry_n;
      r_dcnt  <= w_dcnt_n;
      r_fail  <= w_fail_n;
      r_tmr   <= w_tmr_n;
      r_open  <= w_open_n;
      r_alarm <= (w_nxt == LOCKOUT);
      r_sw_s1 <= sw_x;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign open      = r_open;
  assign alarm     = r_alarm;
  assign state     = r_state;
  assign digit_cnt = r_dcnt;
  assign fail_cnt  = r_fail;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed bench for lock_entry_sequencer with short debounce and lockout times.
module tb_lock_entry_sequencer;

  logic       clk;
  logic       reset_n;
  logic       key_enter_n;
  logic       key_lock_n;
  logic       sw_x;
  logic       open;
  logic       alarm;
  logic [2:0] state;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;
`ifdef LOCK_CODE_PROG_EN
  logic       key_prog_n;
`endif

  int checks;
  int failures;

  localparam logic [6:0] GOOD  = 7'b1110111;
  localparam logic [6:0] WRONG = 7'b1111111;

  lock_entry_sequencer #(
    .DEB_CYCLES     (4),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_enter_n (key_enter_n),
    .key_lock_n  (key_lock_n),
`ifdef LOCK_CODE_PROG_EN
    .key_prog_n  (key_prog_n),
`endif
    .sw_x        (sw_x),
    .open        (open),
    .alarm       (alarm),
    .state       (state),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic gap();
    repeat (8) @(negedge clk);
  endtask

  // Pulse reaches the FSM on the 6th rising edge after the key drops.
  task automatic press(input logic b);
    sw_x        = b;
    key_enter_n = 1'b0;
    repeat (6) @(negedge clk);
    key_enter_n = 1'b1;
  endtask

  task automatic lock_press();
    key_lock_n = 1'b0;
    repeat (6) @(negedge clk);
    key_lock_n = 1'b1;
  endtask

`ifdef LOCK_CODE_PROG_EN
  task automatic prog_press();
    key_prog_n = 1'b0;
    repeat (6) @(negedge clk);
    key_prog_n = 1'b1;
  endtask
`endif

  task automatic enter_bits(input logic [6:0] c, input int n);
    logic [6:0] v;
    v = c;
    for (int i = 6; i > 6 - n; i--) begin
      press(v[i]);
      gap();
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    key_enter_n = 1'b1;
    key_lock_n  = 1'b1;
    sw_x        = 1'b0;
`ifdef LOCK_CODE_PROG_EN
    key_prog_n  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_open", 32'(open), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_digit", 32'(digit_cnt), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    reset_n = 1'b1;
    gap();

    // Correct code opens two cycles after the last enter pulse
    enter_bits(GOOD, 6);
    chk("t1_digit6", 32'(digit_cnt), 32'd6);
    chk("t1_entry_state", 32'(state), 32'd1);
    press(GOOD[0]);
    chk("t1_check_state", 32'(state), 32'd2);
    chk("t1_open_early", 32'(open), 32'd0);
    @(negedge clk);
    chk("t1_open_state", 32'(state), 32'd3);
    chk("t1_open", 32'(open), 32'd1);
    chk("t1_fail", 32'(fail_cnt), 32'd0);
    chk("t1_digit_clr", 32'(digit_cnt), 32'd0);
    gap();
    press(1'b0);
    gap();
    chk("t1_enter_ignored", 32'(state), 32'd3);
    lock_press();
    gap();
    chk("t1_lock_state", 32'(state), 32'd0);
    chk("t1_lock_open", 32'(open), 32'd0);

    // Three wrong codes -> lockout for 20 cycles
    enter_bits(WRONG, 7);
    chk("t2_fail1", 32'(fail_cnt), 32'd1);
    chk("t2_idle1", 32'(state), 32'd0);
    enter_bits(WRONG, 7);
    chk("t2_fail2", 32'(fail_cnt), 32'd2);
    enter_bits(WRONG, 6);
    press(WRONG[0]);
    chk("t2_check", 32'(state), 32'd2);
    @(negedge clk);
    chk("t2_lockout", 32'(state), 32'd4);
    chk("t2_alarm_on", 32'(alarm), 32'd1);
    press(1'b1);
    lock_press();
    chk("t2_keys_ignored", 32'(state), 32'd4);
    chk("t2_digit_lock", 32'(digit_cnt), 32'd0);
    repeat (7) @(negedge clk);
    chk("t2_alarm_last", 32'(alarm), 32'd1);
    @(negedge clk);
    chk("t2_alarm_off", 32'(alarm), 32'd0);
    chk("t2_idle_after", 32'(state), 32'd0);
    chk("t2_fail_clr", 32'(fail_cnt), 32'd0);
    gap();

    // Abort after three bits, then a correct code
    enter_bits(GOOD, 3);
    chk("t3_digit3", 32'(digit_cnt), 32'd3);
    lock_press();
    gap();
    chk("t3_abort_state", 32'(state), 32'd0);
    chk("t3_abort_digit", 32'(digit_cnt), 32'd0);
    enter_bits(GOOD, 7);
    chk("t3_open", 32'(open), 32'd1);
    lock_press();
    gap();

    // Simultaneous enter and lock in ENTRY: lock wins
    enter_bits(GOOD, 1);
    chk("t4_entry", 32'(state), 32'd1);
    sw_x        = 1'b1;
    key_enter_n = 1'b0;
    key_lock_n  = 1'b0;
    repeat (6) @(negedge clk);
    key_enter_n = 1'b1;
    key_lock_n  = 1'b1;
    gap();
    chk("t4_state", 32'(state), 32'd0);
    chk("t4_digit", 32'(digit_cnt), 32'd0);
    enter_bits(GOOD, 7);
    chk("t4_reopen", 32'(open), 32'd1);
    lock_press();
    gap();

    // Short bounce, then asynchronous reset in OPEN and in LOCKOUT
    key_enter_n = 1'b0;
    repeat (2) @(negedge clk);
    key_enter_n = 1'b1;
    gap();
    chk("t5_bounce_state", 32'(state), 32'd0);
    chk("t5_bounce_digit", 32'(digit_cnt), 32'd0);
    enter_bits(GOOD, 7);
    chk("t5_open_pre", 32'(open), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_open", 32'(open), 32'd0);
    chk("t5_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    gap();
    enter_bits(WRONG, 7);
    enter_bits(WRONG, 7);
    enter_bits(WRONG, 7);
    chk("t5_alarm_pre", 32'(alarm), 32'd1);
    chk("t5_fail_pre", 32'(fail_cnt), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_alarm", 32'(alarm), 32'd0);
    chk("t5_rst_state2", 32'(state), 32'd0);
    chk("t5_rst_fail", 32'(fail_cnt), 32'd0);
    chk("t5_rst_digit", 32'(digit_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    gap();

`ifdef LOCK_CODE_PROG_EN
    // Programming a new code from OPEN
    enter_bits(GOOD, 7);
    prog_press();
    gap();
    chk("t6_prog_state", 32'(state), 32'd5);
    chk("t6_prog_open", 32'(open), 32'd1);
    enter_bits(7'b0101010, 7);
    chk("t6_back_open", 32'(state), 32'd3);
    lock_press();
    gap();
    enter_bits(GOOD, 7);
    chk("t6_old_fails", 32'(fail_cnt), 32'd1);
    enter_bits(7'b0101010, 7);
    chk("t6_new_opens", 32'(open), 32'd1);
    prog_press();
    gap();
    enter_bits(7'b0000000, 2);
    lock_press();
    gap();
    chk("t6_abort_prog", 32'(state), 32'd0);
    enter_bits(7'b0101010, 7);
    chk("t6_code_kept", 32'(open), 32'd1);
    lock_press();
    gap();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
